// File: rtl/usb_pkg.sv
// Shared USB protocol constants, controller state encoding and token builder
// for the USB memory-transfer controller.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b1000;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [7:0] PID_DATA0 = 8'hC3;

  localparam logic [3:0] EP_ADDR = 4'd4;
  localparam logic [3:0] EP_DATA = 4'd8;

  localparam int TOK_W  = 19;
  localparam int DATA_W = 72;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ADDR_ISSUE = 3'd1,
    ST_ADDR_WAIT  = 3'd2,
    ST_DATA_ISSUE = 3'd3,
    ST_DATA_WAIT  = 3'd4,
    ST_RESP       = 3'd5
  } state_t;

  // Token layout: PID, device address, endpoint, four reserved zero bits.
  function automatic logic [TOK_W-1:0] mk_token(input logic [3:0] pid,
                                                input logic [6:0] dev,
                                                input logic [3:0] ep);
    mk_token = {pid, dev, ep, 4'd0};
  endfunction

endpackage

// File: rtl/xfer_watchdog.sv
// Per-transaction timeout counter: cleared before each wait phase, counts
// while enabled, flags expiry when the count reaches MAX.
module xfer_watchdog #(
  parameter logic [11:0] MAX = 12'd4095
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [11:0] r_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt <= 12'd0;
    end else if (clr) begin
      r_cnt <= 12'd0;
    end else if (en && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + 12'd1;
    end
  end

  assign expired = en && (r_cnt == MAX);

endmodule

// File: rtl/usb_xfer_ctrl.sv
// Turns a host memory request into a two-phase USB exchange (address OUT,
// then data OUT or IN) with the protocol engine, guarded by a watchdog.
module usb_xfer_ctrl
  import usb_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'd5,
  parameter logic [11:0] WDOG_MAX = 12'd4095
) (
  input  logic               clk,
  input  logic               rst_b,
  // Host side
  input  logic               req_valid,
  input  logic               req_write,
  input  logic [15:0]        req_addr,
  input  logic [63:0]        req_wdata,
  output logic               req_ready,
  output logic               rsp_valid,
  output logic               rsp_ok,
  output logic [63:0]        rsp_rdata,
  // Engine side
  output logic [TOK_W-1:0]   tok_out,
  output logic [DATA_W-1:0]  data_out,
  output logic               tok_avail,
  input  logic               eng_ready,
  input  logic               eng_done,
  input  logic               eng_success,
  input  logic [63:0]        eng_rdata,
  // Debug visibility of the controller state
  output state_t             dbg_state
);

  // Handshakes: a request is taken when req_valid && req_ready on a rising
  // edge; a token is taken when tok_avail is high (only raised with eng_ready).

  state_t             r_state;
  state_t             w_next;
  logic               r_write;
  logic [15:0]        r_addr;
  logic [63:0]        r_wdata;
  logic               r_ok;
  logic [63:0]        r_rdata;

  logic               w_capture;
  logic               w_set_ok;
  logic               w_ok_val;
  logic               w_cap_rdata;
  logic               w_wd_clr;
  logic               w_wd_en;
  logic               w_wd_expired;
  logic               w_tok_avail;
  logic [TOK_W-1:0]   w_tok;
  logic [DATA_W-1:0]  w_data;

  xfer_watchdog #(
    .MAX (WDOG_MAX)
  ) u_wdog (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr     (w_wd_clr),
    .en      (w_wd_en),
    .expired (w_wd_expired)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_capture   = 1'b0;
    w_set_ok    = 1'b0;
    w_ok_val    = 1'b0;
    w_cap_rdata = 1'b0;
    w_wd_clr    = 1'b0;
    w_wd_en     = 1'b0;
    w_tok_avail = 1'b0;
    w_tok       = '0;
    w_data      = '0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_capture = 1'b1;
          w_next    = ST_ADDR_ISSUE;
        end
      end
      ST_ADDR_ISSUE: begin
        w_tok  = mk_token(PID_OUT, DEV_ADDR, EP_ADDR);
        w_data = {PID_DATA0, 48'd0, r_addr};
        if (eng_ready) begin
          w_tok_avail = 1'b1;
          w_wd_clr    = 1'b1;
          w_next      = ST_ADDR_WAIT;
        end
      end
      ST_ADDR_WAIT: begin
        w_wd_en = 1'b1;
        // A completion on the expiry cycle still counts as a completion.
        if (eng_done) begin
          if (eng_success) begin
            w_next = ST_DATA_ISSUE;
          end else begin
            w_set_ok = 1'b1;
            w_next   = ST_RESP;
          end
        end else if (w_wd_expired) begin
          w_set_ok = 1'b1;
          w_next   = ST_RESP;
        end
      end
      ST_DATA_ISSUE: begin
        w_tok  = mk_token(r_write ? PID_OUT : PID_IN, DEV_ADDR, EP_DATA);
        w_data = {PID_DATA0, (r_write ? r_wdata : 64'd0)};
        if (eng_ready) begin
          w_tok_avail = 1'b1;
          w_wd_clr    = 1'b1;
          w_next      = ST_DATA_WAIT;
        end
      end
      ST_DATA_WAIT: begin
        w_wd_en = 1'b1;
        if (eng_done) begin
          w_set_ok    = 1'b1;
          w_ok_val    = eng_success;
          w_cap_rdata = eng_success && !r_write;
          w_next      = ST_RESP;
        end else if (w_wd_expired) begin
          w_set_ok = 1'b1;
          w_next   = ST_RESP;
        end
      end
      ST_RESP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_write <= 1'b0;
      r_addr  <= 16'd0;
      r_wdata <= 64'd0;
      r_ok    <= 1'b0;
      r_rdata <= 64'd0;
    end else begin
      if (w_capture) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_set_ok) begin
        r_ok <= w_ok_val;
      end
      if (w_cap_rdata) begin
        r_rdata <= eng_rdata;
      end
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_ok    = (r_state == ST_RESP) && r_ok;
  assign rsp_rdata = r_rdata;
  assign tok_avail = w_tok_avail;
  assign tok_out   = w_tok;
  assign data_out  = w_data;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_usb_xfer_ctrl.sv
// Directed bench for usb_xfer_ctrl: behavioural engine responder, negedge
// monitor collecting tokens and responses, hand-computed expectations.
module tb_usb_xfer_ctrl;

  logic        clk;
  logic        rst_b;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ok;
  logic [63:0] rsp_rdata;
  logic [18:0] tok_out;
  logic [71:0] data_out;
  logic        tok_avail;
  logic        eng_ready;
  logic        eng_done;
  logic        eng_success;
  logic [63:0] eng_rdata;
  logic [2:0]  dbg_state;

  usb_xfer_ctrl dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ok      (rsp_ok),
    .rsp_rdata   (rsp_rdata),
    .tok_out     (tok_out),
    .data_out    (data_out),
    .tok_avail   (tok_avail),
    .eng_ready   (eng_ready),
    .eng_done    (eng_done),
    .eng_success (eng_success),
    .eng_rdata   (eng_rdata),
    .dbg_state   (dbg_state)
  );

  // Clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  int n_tests = 0;
  int n_fail  = 0;

  logic [18:0] tok_q[$];
  logic [71:0] dat_q[$];
  int          tcyc_q[$];
  int          rsp_n = 0;
  logic        rsp_ok_l;
  logic [63:0] rsp_rd_l;
  int          rsp_cyc;
  int          consec = 0;
  logic        prev_tok = 1'b0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (tok_avail) begin
      tok_q.push_back(tok_out);
      dat_q.push_back(data_out);
      tcyc_q.push_back(cyc);
    end
    if (tok_avail && prev_tok) consec++;
    prev_tok = tok_avail;
    if (rsp_valid) begin
      rsp_n++;
      rsp_ok_l = rsp_ok;
      rsp_rd_l = rsp_rdata;
      rsp_cyc  = cyc;
    end
  end

  // Engine responder: delay -1 means never answer that phase
  int   dly_addr = 0;
  int   dly_data = 0;
  logic succ_addr = 1'b1;
  logic succ_data = 1'b1;

  initial begin
    eng_done    = 1'b0;
    eng_success = 1'b0;
    forever begin
      @(negedge clk);
      if (tok_avail) begin
        int   d;
        logic s;
        d = (tok_out[7:4] == 4'd4) ? dly_addr : dly_data;
        s = (tok_out[7:4] == 4'd4) ? succ_addr : succ_data;
        if (d >= 0) begin
          repeat (d) @(posedge clk);
          @(posedge clk);
          #1;
          eng_done    = 1'b1;
          eng_success = s;
          @(posedge clk);
          #1;
          eng_done    = 1'b0;
          eng_success = 1'b0;
        end
      end
    end
  end

  // Driver tasks (all called at posedge+1)
  int req_cyc;

  task automatic clear_sb();
    tok_q.delete();
    dat_q.delete();
    tcyc_q.delete();
  endtask

  task automatic do_req(input logic w, input logic [15:0] a, input logic [63:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_cyc   = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int bound);
    int start;
    int k;
    start = rsp_n;
    k = 0;
    while (rsp_n == start && k < bound) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(tag, 72'(rsp_n - start), 72'd1);
  endtask

  initial begin
    rst_b     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'd0;
    req_wdata = 64'd0;
    eng_ready = 1'b1;
    eng_rdata = 64'h0123456789ABCDEF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_tok_avail", tok_avail, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_tok_out", tok_out, 0);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);

    // Write, engine always succeeds
    clear_sb();
    do_req(1'b1, 16'h1234, 64'hDEADBEEF_CAFEF00D);
    wait_rsp("wr_rsp_cnt", 40);
    chk("wr_tok_n", tok_q.size(), 2);
    if (tok_q.size() == 2) begin
      chk("wr_tok0", tok_q[0], 19'h40540);
      chk("wr_dat0", dat_q[0], 72'hC3_0000_0000_0000_1234);
      chk("wr_tok1", tok_q[1], 19'h40580);
      chk("wr_dat1", dat_q[1], 72'hC3_DEADBEEF_CAFEF00D);
      chk("wr_lat_tok", tcyc_q[0], req_cyc + 1);
      chk("wr_lat_rsp", rsp_cyc, tcyc_q[1] + 2);
    end
    chk("wr_ok", rsp_ok_l, 1);
    chk("wr_rdata_kept", rsp_rd_l, 64'd0);

    // Read
    clear_sb();
    do_req(1'b0, 16'h00FF, 64'h0);
    wait_rsp("rd_rsp_cnt", 40);
    chk("rd_tok_n", tok_q.size(), 2);
    if (tok_q.size() == 2) begin
      chk("rd_dat0", dat_q[0], 72'hC3_0000_0000_0000_00FF);
      chk("rd_tok1", tok_q[1], 19'h48580);
    end
    chk("rd_ok", rsp_ok_l, 1);
    chk("rd_rdata", rsp_rd_l, 64'h0123456789ABCDEF);

    // Address phase fails
    clear_sb();
    succ_addr = 1'b0;
    do_req(1'b1, 16'h0042, 64'h55);
    wait_rsp("af_rsp_cnt", 40);
    chk("af_tok_n", tok_q.size(), 1);
    chk("af_ok", rsp_ok_l, 0);
    chk("af_rdata_hold", rsp_rdata, 64'h0123456789ABCDEF);
    succ_addr = 1'b1;

    // eng_ready low for 20 cycles in ADDR_ISSUE
    clear_sb();
    eng_ready = 1'b0;
    do_req(1'b1, 16'h0007, 64'h77);
    repeat (20) @(posedge clk);
    #1;
    chk("nr_no_tok", tok_q.size(), 0);
    chk("nr_state", dbg_state, 3'd1);
    eng_ready = 1'b1;
    req_cyc = cyc;
    wait_rsp("nr_rsp_cnt", 40);
    chk("nr_tok_n", tok_q.size(), 2);
    if (tok_q.size() == 2) chk("nr_tok_cyc", tcyc_q[0], req_cyc);
    chk("nr_ok", rsp_ok_l, 1);

    // eng_done while idle is ignored
    begin
      int s0;
      s0 = rsp_n;
      eng_done = 1'b1;
      eng_success = 1'b1;
      @(posedge clk);
      #1;
      eng_done = 1'b0;
      eng_success = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_done_rsp", 72'(rsp_n - s0), 0);
      chk("idle_done_ready", req_ready, 1);
    end

    // Watchdog expiry in ADDR_WAIT, with req_valid noise mid-wait
    clear_sb();
    dly_addr = -1;
    do_req(1'b1, 16'h0100, 64'h1);
    req_valid = 1'b1;
    req_addr  = 16'hBEEF;
    repeat (5) @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_rsp("wd_rsp_cnt", 5000);
    chk("wd_tok_n", tok_q.size(), 1);
    if (tok_q.size() >= 1) begin
      chk("wd_lat", rsp_cyc, tcyc_q[0] + 4097);
      chk("wd_dat0", dat_q[0], 72'hC3_0000_0000_0000_0100);
    end
    chk("wd_ok", rsp_ok_l, 0);

    // eng_done on the expiry cycle wins
    clear_sb();
    dly_addr = 4095;
    do_req(1'b1, 16'h0200, 64'h2);
    wait_rsp("ex_rsp_cnt", 5000);
    chk("ex_tok_n", tok_q.size(), 2);
    if (tok_q.size() == 2) chk("ex_tok1_cyc", tcyc_q[1], tcyc_q[0] + 4097);
    chk("ex_ok", rsp_ok_l, 1);
    dly_addr = 0;

    // Reset during DATA_WAIT
    clear_sb();
    dly_data = -1;
    begin
      int s0;
      s0 = rsp_n;
      do_req(1'b1, 16'h0300, 64'h3);
      repeat (5) @(posedge clk);
      #1;
      chk("rs_state", dbg_state, 3'd4);
      #2;
      rst_b = 1'b0;
      #1;
      chk("rs_rsp_valid", rsp_valid, 0);
      chk("rs_rsp_ok", rsp_ok, 0);
      chk("rs_rdata", rsp_rdata, 0);
      chk("rs_tok_avail", tok_avail, 0);
      chk("rs_tok_out", tok_out, 0);
      chk("rs_data_out", data_out, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_b = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("rs_req_ready", req_ready, 1);
      chk("rs_no_rsp", 72'(rsp_n - s0), 0);
    end
    dly_data = 0;

    chk("tok_consec", consec, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
